// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU operation sequencer: IDLE -> EXEC (N cycles) -> DONE with result capture.
// Optional macro ALU_SEQ_DIV0_TRAP_EN turns a Divide by zero into an immediate error completion.
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] ra,
    input  logic [31:0] rb,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_zhi,
    input  logic [31:0] alu_zlo,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [4:0] OP_FIRST = 5'b00011;
    localparam logic [4:0] OP_LAST  = 5'b10001;
    localparam logic [4:0] OP_MUL   = 5'b01110;
    localparam logic [4:0] OP_DIV   = 5'b01111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] zhi_q, zhi_d;
    logic [31:0] zlo_q, zlo_d;
    logic        err_q, err_d;

    logic        opValid;
    logic        divTrap;
    logic [5:0]  nCycles;

    assign opValid = (opcode >= OP_FIRST) && (opcode <= OP_LAST);

`ifdef ALU_SEQ_DIV0_TRAP_EN
    assign divTrap = (opcode == OP_DIV) && (rb == 32'd0);
`else
    assign divTrap = 1'b0;
`endif

    always_comb begin
        nCycles = 6'd1;
        if (opcode == OP_MUL) begin
            nCycles = 6'(MUL_CYCLES);
        end else if (opcode == OP_DIV) begin
            nCycles = 6'(DIV_CYCLES);
        end
    end

    // Rejected requests still latch their operands but complete at once with zeroed results.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = opcode;
                    a_d  = ra;
                    b_d  = rb;
                    if (!opValid || divTrap) begin
                        cnt_d   = 6'd0;
                        zhi_d   = 32'd0;
                        zlo_d   = 32'd0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = nCycles - 6'd1;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    zhi_d   = alu_zhi;
                    zlo_d   = alu_zlo;
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            zhi_q   <= 32'd0;
            zlo_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            err_q   <= err_d;
        end
    end

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign z_hi   = zhi_q;
    assign z_lo   = zlo_q;
    assign err    = err_q;
    assign busy   = (state_q == EXEC);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: transaction-level timing model plus directed literal checks.
// Expectations follow ALU_SEQ_DIV0_TRAP_EN when it is defined for the build.
module tb_alu_op_sequencer;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;
`ifdef ALU_SEQ_DIV0_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [31:0] ra = 32'd0;
    logic [31:0] rb = 32'd0;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_zhi, alu_zlo, z_hi, z_lo;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;
    bit cmpEn = 1'b0;
    int dutDones = 0;
    int modelDones = 0;

    alu_op_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clock(clock), .clear_n(clear_n), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_zhi(alu_zhi), .alu_zlo(alu_zlo), .z_hi(z_hi), .z_lo(z_lo),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // Stand-in ALU: 3 adds, 4 subtracts, 14 multiplies, 15 divides (hi = remainder).
    function automatic logic [63:0] aluFn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        case (op)
            5'd3:    r = {32'd0, a + b};
            5'd4:    r = {32'd0, a - b};
            5'd14:   r = {32'd0, a} * {32'd0, b};
            5'd15:   r = (b == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
            default: r = {a ^ b, a + {27'd0, op}};
        endcase
        return r;
    endfunction

    assign {alu_zhi, alu_zlo} = aluFn(alu_op, alu_a, alu_b);

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: each request is described by its accept edge, its length and its completion edge.
    int          mEdge = 0;
    int          mAcc = -100;
    int          mN = 0;
    int          mDoneEdge = -100;
    bit          mImm = 1'b0;
    logic [4:0]  mOp = 5'd0;
    logic [31:0] mA = 32'd0, mB = 32'd0, mZhi = 32'd0, mZlo = 32'd0;
    bit          mErr = 1'b0;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            mAcc = -100; mN = 0; mDoneEdge = -100; mImm = 1'b0;
            mOp = 5'd0; mA = 32'd0; mB = 32'd0; mZhi = 32'd0; mZlo = 32'd0; mErr = 1'b0;
        end else begin
            mEdge++;
            if (mEdge > mDoneEdge + 1 && start) begin
                mOp = opcode; mA = ra; mB = rb; mAcc = mEdge;
                mImm = (opcode < 5'd3) || (opcode > 5'd17) || (TRAP && opcode == 5'd15 && rb == 32'd0);
                mN = (opcode == 5'd14) ? MUL_N : (opcode == 5'd15) ? DIV_N : 1;
                mDoneEdge = mImm ? mEdge : mEdge + mN;
                if (mImm) begin
                    mZhi = 32'd0; mZlo = 32'd0; mErr = 1'b1;
                end
            end else if (!mImm && mEdge == mDoneEdge) begin
                {mZhi, mZlo} = aluFn(mOp, mA, mB);
                mErr = 1'b0;
            end
            if (mEdge == mDoneEdge) modelDones++;
        end
    end

    always @(negedge clock) begin
        if (cmpEn) begin
            if (done) dutDones++;
            checkOutput("busy", 64'(busy), 64'(!mImm && mEdge >= mAcc && mEdge < mAcc + mN));
            checkOutput("done", 64'(done), 64'(mEdge == mDoneEdge));
            checkOutput("err", 64'(err), 64'(mErr));
            checkOutput("z_hi", 64'(z_hi), 64'(mZhi));
            checkOutput("z_lo", 64'(z_lo), 64'(mZlo));
            checkOutput("alu_op", 64'(alu_op), 64'(mOp));
            checkOutput("alu_a", 64'(alu_a), 64'(mA));
            checkOutput("alu_b", 64'(alu_b), 64'(mB));
        end
    end

    // One request; latency is the edge (relative to accept) at which done is first seen high.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int latency, output int busyCycles);
        @(negedge clock);
        start = 1'b1; opcode = op; ra = a; rb = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; ra = ~a; rb = b + 32'd1; opcode = 5'($urandom);
        latency = -1;
        busyCycles = 0;
        for (int j = 0; j < 100; j++) begin
            if (busy) busyCycles++;
            if (done) begin
                latency = j + 1;
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                break;
            end
            start = j[0];
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    int lat, bc;

    initial begin
        repeat (3) @(posedge clock);
        cmpEn = 1'b1;
        @(negedge clock);
        checkOutput("reset_z_lo", 64'(z_lo), 64'd0);
        checkOutput("reset_alu_a", 64'(alu_a), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        clear_n = 1'b1;

        applyStimulus(5'd3, 32'd5, 32'd7, lat, bc);
        checkOutput("add_latency", 64'(lat), 64'd2);
        checkOutput("add_busy", 64'(bc), 64'd1);
        checkOutput("add_z_lo", 64'(z_lo), 64'd12);
        checkOutput("add_z_hi", 64'(z_hi), 64'd0);
        checkOutput("add_err", 64'(err), 64'd0);

        applyStimulus(5'd14, 32'h10000, 32'h10000, lat, bc);
        checkOutput("mul_latency", 64'(lat), 64'd5);
        checkOutput("mul_busy", 64'(bc), 64'd4);
        checkOutput("mul_z_hi", 64'(z_hi), 64'd1);
        checkOutput("mul_z_lo", 64'(z_lo), 64'd0);

        applyStimulus(5'd31, 32'd1, 32'd2, lat, bc);
        checkOutput("bad_latency", 64'(lat), 64'd1);
        checkOutput("bad_busy", 64'(bc), 64'd0);
        checkOutput("bad_err", 64'(err), 64'd1);
        checkOutput("bad_z", {z_hi, z_lo}, 64'd0);

        applyStimulus(5'd15, 32'd9, 32'd0, lat, bc);
`ifdef ALU_SEQ_DIV0_TRAP_EN
        checkOutput("div0_latency", 64'(lat), 64'd1);
        checkOutput("div0_err", 64'(err), 64'd1);
        checkOutput("div0_z", {z_hi, z_lo}, 64'd0);
`else
        checkOutput("div0_latency", 64'(lat), 64'd33);
        checkOutput("div0_err", 64'(err), 64'd0);
        checkOutput("div0_z", {z_hi, z_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        applyStimulus(5'd15, 32'd100, 32'd7, lat, bc);
        checkOutput("div_latency", 64'(lat), 64'd33);
        checkOutput("div_busy", 64'(bc), 64'd32);
        checkOutput("div_z_lo", 64'(z_lo), 64'd14);
        checkOutput("div_z_hi", 64'(z_hi), 64'd2);

        @(negedge clock);
        start = 1'b1; opcode = 5'd15; ra = 32'd100; rb = 32'd7;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2 clear_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_z", {z_hi, z_lo}, 64'd0);
        checkOutput("abort_alu", {27'd0, alu_op, alu_a}, 64'd0);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        applyStimulus(5'd3, 32'd20, 32'd22, lat, bc);
        checkOutput("post_abort_latency", 64'(lat), 64'd2);
        checkOutput("post_abort_z_lo", 64'(z_lo), 64'd42);

        for (int i = 0; i < 2500; i++) begin
            int r;
            @(negedge clock);
            start = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 29);
            if (r < 2) opcode = 5'd14;
            else if (r == 2) opcode = 5'd15;
            else if (r == 3) opcode = 5'($urandom_range(0, 2));
            else if (r == 4) opcode = 5'($urandom_range(18, 31));
            else opcode = 5'($urandom_range(3, 17));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 800 == 400) begin
                #1 clear_n = 1'b0;
                #2 clear_n = 1'b1;
            end
        end

        @(negedge clock);
        start = 1'b0;
        repeat (40) @(negedge clock);
        checkOutput("done_count", 64'(dutDones), 64'(modelDones));
        cmpEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 4: EXEC cycles held for Multiply (5'b01110); legal 1..31.
REQ-002 Parameter DIV_CYCLES, default 32: EXEC cycles held for Divide (5'b01111); legal 1..63.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 clear_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 opcode  in  5  operation code, same encoding as the ALU.
REQ-007 ra, rb  in  32 each  operands.
REQ-008 alu_op  out  5  opcode driven to the ALU.
REQ-009 alu_a, alu_b  out  32 each  operands driven to the ALU.
REQ-010 alu_zhi, alu_zlo  in  32 each  ALU results.
REQ-011 z_hi, z_lo  out  32 each  captured results.
REQ-012 busy  out  1  high in EXEC.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  error flag, valid while done=1.

Function
REQ-015 States: IDLE, EXEC, DONE; one-hot or binary encoding is free.
REQ-016 IDLE with start=1: latch opcode/ra/rb, load cnt = N-1, go EXEC; N=MUL_CYCLES for Multiply, DIV_CYCLES for Divide, else 1.
REQ-017 Valid opcodes: 5'b00011 through 5'b10001 inclusive.
REQ-018 Invalid opcode at start: skip EXEC, go straight to DONE, err=1, z_hi/z_lo forced to 0.
REQ-019 alu_op/alu_a/alu_b hold the latched values from accept until the next accept; all three are 0 after reset.
REQ-020 EXEC, cnt!=0: decrement cnt.
REQ-021 EXEC, cnt==0: capture alu_zhi->z_hi and alu_zlo->z_lo; go DONE.
REQ-022 Latency: start sampled at edge E0 -> done high in the cycle after edge E0+N+1. Single-cycle ops give E0+2; invalid opcodes give E0+1.
REQ-023 DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally; start is ignored in DONE and EXEC (no queueing).
REQ-024 z_hi/z_lo/err hold their values until the next capture or reset.
REQ-025 opcode/ra/rb changes after accept do not affect the operation in flight.
REQ-026 Back-to-back: start held high re-accepts in IDLE, giving one request per N+2 cycles.

Reset
REQ-027 clear_n low asynchronously forces state IDLE, cnt=0, busy=0, done=0, err=0, z_hi=z_lo=0, alu_op=0, alu_a=alu_b=0.
REQ-028 Reset mid-EXEC aborts the operation with no done pulse and no capture; the first accept is possible on the first rising edge after clear_n rises.

Configuration
REQ-029 Macro ALU_SEQ_DIV0_TRAP_EN defined: Divide with rb==0 at accept goes straight to DONE with err=1 and z_hi=z_lo=0, skipping EXEC.
REQ-030 Macro ALU_SEQ_DIV0_TRAP_EN undefined: Divide with rb==0 runs DIV_CYCLES normally, err=0, and captures whatever the ALU returns.

Verification
REQ-031 Addition ra=5, rb=7, start at E0 -> done after E0+2, z_lo=12, z_hi=0, err=0; busy high for exactly 1 cycle.
REQ-032 Multiply ra=32'h10000, rb=32'h10000, default params -> busy for 4 cycles, done after E0+5, z_hi=1, z_lo=0.
REQ-033 opcode=5'b11111 -> done after E0+1, err=1, z_hi=z_lo=0, busy never high.
REQ-034 Divide rb=0: with macro -> done after E0+1, err=1; without macro -> done after E0+33, err=0.
REQ-035 clear_n pulsed low in the 10th EXEC cycle of a Divide -> outputs zero immediately, no done; new Addition after release completes normally.
REQ-036 start pulsed during EXEC and DONE -> ignored; exactly one done per accepted request; changing ra mid-EXEC leaves the result unchanged.
